// File: rtl/cv32e40p_tmr_vote_monitor_ft.sv
// TMR word-level voter with per-replica breakage counters and repair.
// Optional error log ports/registers when CV32E40P_FT_ERR_LOG_EN is defined.
module cv32e40p_tmr_vote_monitor_ft #(
    parameter int unsigned NSIG      = 3,
    parameter int unsigned W         = 1,
    parameter int unsigned INCREMENT = 4,
    parameter int unsigned DECREMENT = 1,
    parameter int unsigned THRESHOLD = 32,
    parameter int unsigned COUNT_BIT = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3*NSIG*W-1:0]   to_vote_i,
    output logic [NSIG*W-1:0]     voted_o,
    input  logic [2:0]            set_broken_i,
    input  logic [2:0]            clr_broken_i,
    output logic [2:0]            is_broken_o,
    output logic                  err_detected_o,
    output logic                  err_corrected_o,
    output logic                  uncorrectable_o
`ifdef CV32E40P_FT_ERR_LOG_EN
    ,
    input  logic                  err_log_clr_i,
    output logic                  err_log_valid_o,
    output logic [((NSIG>1)?$clog2(NSIG):1)-1:0] err_log_sig_o,
    output logic [1:0]            err_log_rep_o,
    output logic [15:0]           err_count_o
`endif
);

    localparam int unsigned LW = (NSIG > 1) ? $clog2(NSIG) : 1;
    localparam logic [COUNT_BIT-1:0] CMAX  = '1;
    localparam logic [COUNT_BIT-1:0] INC_C = COUNT_BIT'(INCREMENT);
    localparam logic [COUNT_BIT-1:0] DEC_C = COUNT_BIT'(DECREMENT);
    localparam logic [COUNT_BIT-1:0] THR_C = COUNT_BIT'(THRESHOLD);

    logic [2:0]           brk_q, brk_d;
    logic [COUNT_BIT-1:0] cnt_q [3];
    logic [COUNT_BIT-1:0] cnt_d [3];
    logic [2:0]           blk_err;
    logic [NSIG-1:0]      sig_mis;
    logic [W-1:0]         a, b, c, v;

    assign is_broken_o = brk_q;

    always_comb begin
        voted_o        = '0;
        err_detected_o = 1'b0;
        uncorrectable_o = 1'b0;
        blk_err        = '0;
        sig_mis        = '0;
        a = '0;
        b = '0;
        c = '0;
        v = '0;
        for (int s = 0; s < NSIG; s++) begin
            a = to_vote_i[s*W +: W];
            b = to_vote_i[(NSIG+s)*W +: W];
            c = to_vote_i[(2*NSIG+s)*W +: W];
            v = a;
            case (brk_q)
                3'b000: begin
                    if (a == b || a == c) v = a;
                    else if (b == c)      v = b;
                    if (a != b || a != c) begin
                        err_detected_o = 1'b1;
                        if (a != b && a != c && b != c) begin
                            uncorrectable_o = 1'b1;
                        end else begin
                            // only signals with a majority attribute blame
                            sig_mis[s] = 1'b1;
                            blk_err[0] = blk_err[0] | (a != v);
                            blk_err[1] = blk_err[1] | (b != v);
                            blk_err[2] = blk_err[2] | (c != v);
                        end
                    end
                end
                3'b001: begin
                    v = b;
                    if (b != c) begin
                        err_detected_o  = 1'b1;
                        uncorrectable_o = 1'b1;
                    end
                end
                3'b010: begin
                    v = a;
                    if (a != c) begin
                        err_detected_o  = 1'b1;
                        uncorrectable_o = 1'b1;
                    end
                end
                3'b100: begin
                    v = a;
                    if (a != b) begin
                        err_detected_o  = 1'b1;
                        uncorrectable_o = 1'b1;
                    end
                end
                3'b011:  v = c;
                3'b101:  v = b;
                3'b110:  v = a;
                default: begin
                    v = a;
                    uncorrectable_o = 1'b1;
                end
            endcase
            voted_o[s*W +: W] = v;
        end
    end

    assign err_corrected_o = err_detected_o & ~uncorrectable_o;

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            brk_d[r] = brk_q[r];
            cnt_d[r] = cnt_q[r];
            if (set_broken_i[r]) begin
                brk_d[r] = 1'b1;
            end else if (clr_broken_i[r]) begin
                brk_d[r] = 1'b0;
                cnt_d[r] = '0;
            end else if (!brk_q[r]) begin
                if (blk_err[r]) begin
                    cnt_d[r] = (cnt_q[r] > CMAX - INC_C) ? CMAX
                                                         : cnt_q[r] + INC_C;
                end else begin
                    cnt_d[r] = (cnt_q[r] < DEC_C) ? '0 : cnt_q[r] - DEC_C;
                end
                if (cnt_d[r] >= THR_C) brk_d[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            brk_q <= '0;
            for (int r = 0; r < 3; r++) cnt_q[r] <= '0;
        end else begin
            brk_q <= brk_d;
            for (int r = 0; r < 3; r++) cnt_q[r] <= cnt_d[r];
        end
    end

`ifdef CV32E40P_FT_ERR_LOG_EN
    logic          log_valid_q;
    logic [LW-1:0] log_sig_q, first_sig;
    logic [1:0]    log_rep_q, first_rep;
    logic [15:0]   log_cnt_q;

    always_comb begin
        first_sig = '0;
        for (int s = NSIG - 1; s >= 0; s--) begin
            if (sig_mis[s]) first_sig = LW'(s);
        end
        if (blk_err[0])      first_rep = 2'd0;
        else if (blk_err[1]) first_rep = 2'd1;
        else                 first_rep = 2'd2;
    end

    always_ff @(posedge clk) begin
        if (rst || err_log_clr_i) begin
            log_valid_q <= 1'b0;
            log_sig_q   <= '0;
            log_rep_q   <= '0;
            log_cnt_q   <= '0;
        end else begin
            if (!log_valid_q && |blk_err) begin
                log_valid_q <= 1'b1;
                log_sig_q   <= first_sig;
                log_rep_q   <= first_rep;
            end
            if (err_corrected_o && log_cnt_q != 16'hFFFF) begin
                log_cnt_q <= log_cnt_q + 16'd1;
            end
        end
    end

    assign err_log_valid_o = log_valid_q;
    assign err_log_sig_o   = log_sig_q;
    assign err_log_rep_o   = log_rep_q;
    assign err_count_o     = log_cnt_q;
`else
    logic unused_lw;
    assign unused_lw = (LW == 0);
`endif

endmodule

// File: tb/tb_cv32e40p_tmr_vote_monitor_ft.sv
// Directed bench for the TMR vote monitor, default parameters.
module tb_cv32e40p_tmr_vote_monitor_ft;

    logic       clk;
    logic       rst;
    logic [8:0] tv;
    logic [2:0] voted;
    logic [2:0] set_b;
    logic [2:0] clr_b;
    logic [2:0] brk;
    logic       det, cor, unc;
    int         checks = 0;
    int         errors = 0;
`ifdef CV32E40P_FT_ERR_LOG_EN
    logic        log_clr;
    logic        log_valid;
    logic [1:0]  log_sig;
    logic [1:0]  log_rep;
    logic [15:0] log_cnt;
`endif

    cv32e40p_tmr_vote_monitor_ft dut (
        .clk             (clk),
        .rst             (rst),
        .to_vote_i       (tv),
        .voted_o         (voted),
        .set_broken_i    (set_b),
        .clr_broken_i    (clr_b),
        .is_broken_o     (brk),
        .err_detected_o  (det),
        .err_corrected_o (cor),
        .uncorrectable_o (unc)
`ifdef CV32E40P_FT_ERR_LOG_EN
        ,
        .err_log_clr_i   (log_clr),
        .err_log_valid_o (log_valid),
        .err_log_sig_o   (log_sig),
        .err_log_rep_o   (log_rep),
        .err_count_o     (log_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

    function automatic logic [8:0] pk(input logic [2:0] r0,
                                      input logic [2:0] r1,
                                      input logic [2:0] r2);
        return {r2, r1, r0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        tv    = pk(3'b111, 3'b111, 3'b111);
        set_b = '0;
        clr_b = '0;
`ifdef CV32E40P_FT_ERR_LOG_EN
        log_clr = 1'b0;
`endif
        tick;
        tick;
        chk("reset_brk", brk, 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            #1;
            chk("clean_voted", voted, 7);
            chk("clean_det", det, 0);
            chk("clean_cor", cor, 0);
            chk("clean_unc", unc, 0);
            tick;
        end
        chk("clean_brk", brk, 0);

        tv = pk(3'b111, 3'b111, 3'b101);
        for (int k = 1; k <= 8; k++) begin
            #1;
            chk("r2err_voted", voted, 7);
            chk("r2err_det", det, 1);
            chk("r2err_cor", cor, 1);
            tick;
            chk("r2err_brk", brk, (k == 8) ? 4 : 0);
        end
        #1;
        chk("r2brk_det", det, 0);
        chk("r2brk_cor", cor, 0);
        chk("r2brk_voted", voted, 7);

        set_b = 3'b100;
        clr_b = 3'b100;
        tick;
        chk("setclr_brk", brk, 4);
        set_b = '0;
        tick;
        chk("clr_brk", brk, 0);
        clr_b = '0;

        for (int k = 1; k <= 8; k++) begin
            tick;
            chk("rebrk_brk", brk, (k == 8) ? 4 : 0);
        end
        tv    = pk(3'b111, 3'b111, 3'b111);
        clr_b = 3'b100;
        tick;
        clr_b = '0;
        chk("repair_brk", brk, 0);

        set_b = 3'b010;
        tick;
        set_b = '0;
        chk("r1set_brk", brk, 2);
        tv = pk(3'b111, 3'b000, 3'b110);
        #1;
        chk("onebrk_voted", voted, 7);
        chk("onebrk_det", det, 1);
        chk("onebrk_unc", unc, 1);
        chk("onebrk_cor", cor, 0);
        tv = pk(3'b111, 3'b000, 3'b111);
        #1;
        chk("onebrk_eq_det", det, 0);
        chk("onebrk_eq_unc", unc, 0);
        set_b = 3'b100;
        tick;
        set_b = '0;
        tv = pk(3'b101, 3'b011, 3'b010);
        #1;
        chk("twobrk_voted", voted, 5);
        chk("twobrk_det", det, 0);
        chk("twobrk_unc", unc, 0);
        set_b = 3'b001;
        tick;
        set_b = '0;
        #1;
        chk("threebrk_brk", brk, 7);
        chk("threebrk_voted", voted, 5);
        chk("threebrk_unc", unc, 1);
        chk("threebrk_det", det, 0);
        clr_b = 3'b111;
        tv    = pk(3'b111, 3'b111, 3'b111);
        tick;
        clr_b = '0;
        chk("clrall_brk", brk, 0);

        tv = pk(3'b110, 3'b111, 3'b111);
        tick;
        tv = pk(3'b111, 3'b111, 3'b111);
        repeat (4) tick;
        for (int k = 1; k <= 11; k++) begin
            tv = pk(3'b110, 3'b111, 3'b111);
            tick;
            chk("alt_brk", brk, (k == 11) ? 1 : 0);
            if (k < 11) begin
                tv = pk(3'b111, 3'b111, 3'b111);
                tick;
            end
        end
        tv    = pk(3'b111, 3'b111, 3'b111);
        clr_b = 3'b001;
        tick;
        clr_b = '0;
        chk("alt_clr_brk", brk, 0);

        rst   = 1'b1;
        set_b = 3'b111;
        tick;
        chk("rst_wins_brk", brk, 0);
        rst   = 1'b0;
        set_b = '0;
        tick;
        chk("post_rst_brk", brk, 0);

`ifdef CV32E40P_FT_ERR_LOG_EN
        tv = pk(3'b111, 3'b011, 3'b111);
        #1;
        chk("log1_cor", cor, 1);
        tick;
        chk("log1_valid", log_valid, 1);
        chk("log1_sig", log_sig, 2);
        chk("log1_rep", log_rep, 1);
        chk("log1_cnt", log_cnt, 1);
        tv = pk(3'b110, 3'b111, 3'b111);
        tick;
        chk("log2_sig", log_sig, 2);
        chk("log2_rep", log_rep, 1);
        chk("log2_cnt", log_cnt, 2);
        tv      = pk(3'b111, 3'b111, 3'b111);
        log_clr = 1'b1;
        tick;
        log_clr = 1'b0;
        chk("logclr_valid", log_valid, 0);
        chk("logclr_sig", log_sig, 0);
        chk("logclr_rep", log_rep, 0);
        chk("logclr_cnt", log_cnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
